// File: rtl/rr_pkg.sv
// ============================================================================
// rr_pkg : constants and helpers shared by the round-robin arbiter blocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rr_pkg;

  localparam int NUM_M  = 4;
  localparam int DW_DEF = 8;

  typedef logic [NUM_M-1:0] gnt_t;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/req_fifo.sv
// ============================================================================
// req_fifo : single-master synchronous FIFO with a sticky overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module req_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_ptr_one = (AW+1)'(1);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_ovf;
  logic [DW-1:0] r_mem [DEPTH];

  logic w_do_pop;
  logic w_do_push;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (push && !w_do_push) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign dout = r_mem[r_rd_ptr[AW-1:0]];
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: rtl/rr_req_queue.sv
// ============================================================================
// rr_req_queue : per-master request FIFOs feeding the round-robin arbiter,
//                with grant-selected head presented to the slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_req_queue
  import rr_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:1]          Push,
  input  logic [4:1][DW-1:0]  Din,
  output logic [4:1]          Full,
  output logic [4:1]          Ovf,
  output logic [4:1]          Req,
  input  logic [3:0]          Gnt,
  output logic [DW-1:0]       Dout,
  output logic                Vld,
  input  logic                Rdy
);

  logic [4:1]    w_empty;
  logic [4:1]    w_full;
  logic [4:1]    w_ovf;
  logic [4:1]    w_pop;
  logic [DW-1:0] w_head [1:4];
  logic          w_sel_req;
  logic [DW-1:0] w_sel_head;

  for (genvar gi = 1; gi <= NUM_M; gi++) begin : g_fifo
    req_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (Push[gi]),
      .din   (Din[gi]),
      .pop   (w_pop[gi]),
      .dout  (w_head[gi]),
      .empty (w_empty[gi]),
      .full  (w_full[gi]),
      .ovf   (w_ovf[gi])
    );
  end

  assign Req  = ~w_empty;
  assign Full = w_full;
  assign Ovf  = w_ovf;

  // OR-mux over grant bits; only trusted when the grant is one-hot.
  always_comb begin
    w_sel_req  = 1'b0;
    w_sel_head = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (Gnt[k]) begin
        w_sel_req  = w_sel_req | ~w_empty[k+1];
        w_sel_head = w_sel_head | w_head[k+1];
      end
    end
  end

  assign Vld   = is_onehot4(Gnt) && w_sel_req;
  assign Dout  = Vld ? w_sel_head : '0;
  assign w_pop = Gnt & {NUM_M{Vld && Rdy}};

endmodule

`default_nettype wire

// File: tb/tb_rr_req_queue.sv
// Scoreboard bench for rr_req_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
`default_nettype none

module tb_rr_req_queue;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [4:1]          Push;
  logic [4:1][DW-1:0]  Din;
  logic [4:1]          Full;
  logic [4:1]          Ovf;
  logic [4:1]          Req;
  logic [3:0]          Gnt;
  logic [DW-1:0]       Dout;
  logic                Vld;
  logic                Rdy;

  always #5 clk = ~clk;

  rr_req_queue #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .Push (Push),
    .Din  (Din),
    .Full (Full),
    .Ovf  (Ovf),
    .Req  (Req),
    .Gnt  (Gnt),
    .Dout (Dout),
    .Vld  (Vld),
    .Rdy  (Rdy)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] full;
    logic [3:0] ovf;
    logic       vld;
    logic [7:0] dout;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] xfer_q[$];
  logic [7:0] mq[4][$];
  logic [3:0] movf;
  int         vectors = 0;
  int         miscompares = 0;
  int         cur = -1;
  int         last = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference round-robin arbiter: holds grant while the owner has entries.
  function automatic logic [3:0] arb_pick();
    if (cur >= 0 && mq[cur].size() > 0) return 4'(1) << cur;
    for (int j = 1; j <= 4; j++) begin
      int m;
      m = (last + j) % 4;
      if (mq[m].size() > 0) begin
        cur  = m;
        last = m;
        return 4'(1) << m;
      end
    end
    cur = -1;
    return 4'd0;
  endfunction

  task automatic cycle(input logic [3:0] p, input logic [4:1][7:0] d,
                       input logic [3:0] g, input logic r, input bit use_arb);
    exp_t       e;
    logic [3:0] gg;
    int         k;
    logic       pop;
    @(posedge clk);
    #1;
    gg   = use_arb ? arb_pick() : g;
    Push = p;
    Din  = d;
    Gnt  = gg;
    Rdy  = r;
    k = 0;
    for (int i = 0; i < 4; i++) if (gg[i]) k = i;
    for (int i = 0; i < 4; i++) begin
      e.req[i]  = (mq[i].size() > 0);
      e.full[i] = (mq[i].size() == DEPTH);
    end
    e.ovf  = movf;
    e.vld  = 1'b0;
    if ($countones(gg) == 1) e.vld = (mq[k].size() > 0);
    e.dout = e.vld ? mq[k][0] : 8'h00;
    exp_q.push_back(e);
    pop = e.vld && r;
    if (pop) begin
      xfer_q.push_back(mq[k][0]);
      void'(mq[k].pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(d[i+1]);
        else movf[i] = 1'b1;
      end
    end
  endtask

  task automatic preload_all();
    logic [4:1][7:0] d;
    for (int v = 0; v < 4; v++) begin
      for (int i = 1; i <= 4; i++) d[i] = 8'((i << 4) + v);
      cycle(4'hF, d, 4'd0, 1'b0, 1'b0);
    end
  endtask

  // Monitor: compares every presented cycle and every accepted transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("req",  Req,  e.req);
        chk("full", Full, e.full);
        chk("ovf",  Ovf,  e.ovf);
        chk("vld",  Vld,  e.vld);
        chk("dout", Dout, e.dout);
      end
      if (rst === 1'b1 && Vld === 1'b1 && Rdy === 1'b1) begin
        if (xfer_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL xfer_unexpected: got %0h expected none", Dout);
        end else begin
          chk("xfer_data", Dout, xfer_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:1][7:0] d;
    logic [3:0]      p, g;
    logic            r;
    rst  = 1'b0;
    Push = '0;
    Din  = '0;
    Gnt  = '0;
    Rdy  = 1'b0;
    movf = '0;
    #3;
    chk("rst_req",  Req,  0);
    chk("rst_full", Full, 0);
    chk("rst_ovf",  Ovf,  0);
    chk("rst_vld",  Vld,  0);
    chk("rst_dout", Dout, 0);
    #9 rst = 1'b1;

    // Single push, single pop through grant 2.
    d = '0; d[2] = 8'hA5;
    cycle(4'b0010, d, 4'b0010, 1'b1, 1'b0);
    cycle(4'b0000, '0, 4'b0010, 1'b1, 1'b0);
    cycle(4'b0000, '0, 4'b0010, 1'b1, 1'b0);

    // Fill FIFO 1, overflow, drain in order.
    for (int v = 1; v <= 5; v++) begin
      d = '0; d[1] = 8'(v);
      cycle(4'b0001, d, 4'b0000, 1'b0, 1'b0);
    end
    repeat (5) cycle(4'b0000, '0, 4'b0001, 1'b1, 1'b0);

    // Push into full FIFO 3 while popping it.
    for (int v = 0; v < 4; v++) begin
      d = '0; d[3] = 8'(8'h31 + v);
      cycle(4'b0100, d, 4'b0000, 1'b0, 1'b0);
    end
    d = '0; d[3] = 8'h77;
    cycle(4'b0100, d, 4'b0100, 1'b1, 1'b0);
    cycle(4'b0000, '0, 4'b0000, 1'b0, 1'b0);
    repeat (5) cycle(4'b0000, '0, 4'b0100, 1'b1, 1'b0);

    // Invalid grants and stalled slave.
    d = '0; d[1] = 8'h11; d[4] = 8'h44;
    cycle(4'b1001, d, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, '0, 4'b1001, 1'b1, 1'b0);
    cycle(4'b0000, '0, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, '0, 4'b1000, 1'b0, 1'b0);
    cycle(4'b0000, '0, 4'b1000, 1'b1, 1'b0);
    cycle(4'b0000, '0, 4'b0001, 1'b1, 1'b0);
    cycle(4'b0000, '0, 4'b0000, 1'b0, 1'b0);

    // Closed loop with reference round-robin arbiter.
    preload_all();
    cur = -1; last = 3;
    repeat (18) cycle(4'b0000, '0, 4'b0000, 1'b1, 1'b1);

    // Reset mid-drain.
    preload_all();
    cur = -1; last = 3;
    repeat (6) cycle(4'b0000, '0, 4'b0000, 1'b1, 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_req",  Req,  0);
    chk("midrst_full", Full, 0);
    chk("midrst_ovf",  Ovf,  0);
    chk("midrst_vld",  Vld,  0);
    chk("midrst_dout", Dout, 0);
    for (int i = 0; i < 4; i++) mq[i].delete();
    movf = '0;
    cur  = -1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cycle(4'b0000, '0, 4'b0001, 1'b1, 1'b0);

    // Random traffic.
    repeat (400) begin
      p = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int i = 1; i <= 4; i++) d[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 7) g = 4'(1) << $urandom_range(0, 3);
      else g = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 3) != 0);
      cycle(p, d, g, r, 1'b0);
    end

    @(negedge clk);
    #1;
    chk("exp_q_drained",  exp_q.size(),  0);
    chk("xfer_q_drained", xfer_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
